// File: rtl/hex_display_ctrl_if.sv
// Avalon-MM slave bus bundle for the hex display controller.
// The master drives address/strobes/write data; the slave returns registered read data.
interface hex_display_ctrl_if;
    logic [3:0]  address;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address,
        output read,
        output write,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  read,
        input  write,
        input  writedata,
        output readdata
    );
endinterface

// File: rtl/hex_display_ctrl.sv
// Multi-digit 7-segment display controller with an Avalon-MM register file,
// hex decode / raw segment modes, per-digit blank and blink, and a debounced
// push-button that raises a maskable press interrupt.
module hex_display_ctrl #(
    parameter int NUM_DIGITS      = 6,
    parameter int BLINK_DIV       = 25000000,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic                    clk,
    input  logic                    reset,
    hex_display_ctrl_if.slave       bus,
    input  logic                    button_n,
    output logic [8*NUM_DIGITS-1:0] hex_n,
    output logic                    irq
);

    localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam int DEB_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);
    localparam logic [DEB_W-1:0]   DEB_LAST   = DEB_W'(DEBOUNCE_CYCLES - 1);

    localparam logic [3:0] ADDR_CTRL = 4'd8;
    localparam logic [3:0] ADDR_BTN  = 4'd9;
    localparam logic [3:0] ADDR_EDGE = 4'd10;
    localparam logic [3:0] ADDR_MASK = 4'd11;

    logic [10:0]             r_digit [NUM_DIGITS];
    logic                    r_enable;
    logic                    r_mask;
    logic                    r_edge;
    logic                    r_sync1;
    logic                    r_sync2;
    logic                    r_btn;
    logic                    r_phase;
    logic                    r_irq;
    logic [BLINK_W-1:0]      r_blink_cnt;
    logic [DEB_W-1:0]        r_deb_cnt;
    logic [31:0]             r_readdata;
    logic [8*NUM_DIGITS-1:0] r_hex_n;

    logic [10:0]             w_digit_rd;
    logic [31:0]             w_rdata;
    logic [8*NUM_DIGITS-1:0] w_hex;
    logic                    w_press;
    logic                    w_edge_clr;

    // Hex nibble to active-low g..a segment pattern.
    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            4'hF: seg = 7'h0E;
            default: seg = 7'h7F;
        endcase
        return seg;
    endfunction

    // Active-low byte for one digit: blanked, raw segments, or decoded nibble plus dp.
    function automatic logic [7:0] digit_byte(input logic [10:0] d, input logic en, input logic ph);
        logic [7:0] b;
        if (d[9] || !en || (d[10] && ph)) begin
            b = 8'hFF;
        end else if (d[8]) begin
            b = ~d[7:0];
        end else begin
            b = {~d[4], seg_decode(d[3:0])};
        end
        return b;
    endfunction

    assign w_press    = r_btn & ~r_sync2 & (r_deb_cnt == DEB_LAST);
    assign w_edge_clr = bus.write && (bus.address == ADDR_EDGE) && bus.writedata[0];

    // Per-digit configuration registers; indices beyond NUM_DIGITS have no storage.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_DIGITS; i++) r_digit[i] <= 11'h200;
        end else begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (bus.write && (bus.address == 4'(i))) r_digit[i] <= bus.writedata[10:0];
            end
        end
    end

    // ENABLE and MASK control bits.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_enable <= 1'b1;
            r_mask   <= 1'b0;
        end else begin
            if (bus.write && (bus.address == ADDR_CTRL)) r_enable <= bus.writedata[0];
            if (bus.write && (bus.address == ADDR_MASK)) r_mask   <= bus.writedata[0];
        end
    end

    // Free-running blink divider shared by all digits so blinking stays phase-aligned.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_blink_cnt <= '0;
            r_phase     <= 1'b0;
        end else if (r_blink_cnt == BLINK_LAST) begin
            r_blink_cnt <= '0;
            r_phase     <= ~r_phase;
        end else begin
            r_blink_cnt <= r_blink_cnt + BLINK_W'(1);
        end
    end

    // Two-flop synchroniser for the asynchronous button; idles high (released).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= button_n;
            r_sync2 <= r_sync1;
        end
    end

    // Debouncer: the level follows the synchronised input only after it has differed long enough.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_btn     <= 1'b1;
            r_deb_cnt <= '0;
        end else if (r_sync2 == r_btn) begin
            r_deb_cnt <= '0;
        end else if (r_deb_cnt == DEB_LAST) begin
            r_btn     <= r_sync2;
            r_deb_cnt <= '0;
        end else begin
            r_deb_cnt <= r_deb_cnt + DEB_W'(1);
        end
    end

    // Press capture; a press landing with a write-1-to-clear keeps the flag set.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_edge <= 1'b0;
        end else if (w_press) begin
            r_edge <= 1'b1;
        end else if (w_edge_clr) begin
            r_edge <= 1'b0;
        end else begin
            r_edge <= r_edge;
        end
    end

    // Select the addressed digit register; unmapped indices yield zero.
    always_comb begin
        w_digit_rd = 11'd0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            w_digit_rd = w_digit_rd | ((bus.address == 4'(i)) ? r_digit[i] : 11'd0);
        end
    end

    // Read data mux over the pre-write register values.
    always_comb begin
        w_rdata = 32'd0;
        case (bus.address)
            ADDR_CTRL: w_rdata = {30'd0, r_phase, r_enable};
            ADDR_BTN:  w_rdata = {31'd0, r_btn};
            ADDR_EDGE: w_rdata = {31'd0, r_edge};
            ADDR_MASK: w_rdata = {31'd0, r_mask};
            default:   w_rdata = {21'd0, w_digit_rd};
        endcase
    end

    // Read data is captured only on a read strobe and held otherwise.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_readdata <= 32'd0;
        end else if (bus.read) begin
            r_readdata <= w_rdata;
        end else begin
            r_readdata <= r_readdata;
        end
    end

    // Segment bytes for every digit from the current register state.
    always_comb begin
        w_hex = {(8*NUM_DIGITS){1'b1}};
        for (int i = 0; i < NUM_DIGITS; i++) begin
            w_hex[8*i +: 8] = digit_byte(r_digit[i], r_enable, r_phase);
        end
    end

    // Registered segment outputs and interrupt.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hex_n <= {(8*NUM_DIGITS){1'b1}};
            r_irq   <= 1'b0;
        end else begin
            r_hex_n <= w_hex;
            r_irq   <= r_edge & r_mask;
        end
    end

    assign bus.readdata = r_readdata;
    assign hex_n        = r_hex_n;
    assign irq          = r_irq;

endmodule

// File: tb/tb_hex_display_ctrl.sv
// Self-checking bench for hex_display_ctrl: directed scenarios followed by
// random bus/button traffic, all compared every cycle against a behavioural model.
module tb_hex_display_ctrl;

    localparam int ND = 6;
    localparam int BD = 4;
    localparam int DC = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          button_n;
    logic [8*ND-1:0] hex_n;
    logic          irq;

    hex_display_ctrl_if bus ();

    hex_display_ctrl #(
        .NUM_DIGITS(ND),
        .BLINK_DIV(BD),
        .DEBOUNCE_CYCLES(DC)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus),
        .button_n(button_n),
        .hex_n(hex_n),
        .irq(irq)
    );

    // Free-running 10 ns clock.
    always #5 clk = ~clk;

    int n_err = 0;
    int n_chk = 0;

    // Behavioural model state
    logic [10:0] m_digit [16];
    logic        m_enable, m_mask, m_edge, m_btn;
    logic        m_b1, m_b2;     // button_n as driven one and two edges ago
    int          m_run;          // consecutive edges the synchronised input disagreed with the level
    int          m_n;            // edges since reset release
    logic [31:0] m_rdata;
    logic [6:0]  seg_tab [16];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic phase_now();
        return ((m_n / BD) % 2) == 1;
    endfunction

    function automatic logic [7:0] exp_byte(input logic [10:0] d, input logic en, input logic ph);
        if (d[9] || !en || (d[10] && ph)) return 8'hFF;
        else if (d[8]) return ~d[7:0];
        else return {~d[4], seg_tab[d[3:0]]};
    endfunction

    function automatic logic [8*ND-1:0] exp_hex();
        logic [8*ND-1:0] e;
        for (int i = 0; i < ND; i++) e[8*i +: 8] = exp_byte(m_digit[i], m_enable, phase_now());
        return e;
    endfunction

    function automatic logic [31:0] model_read(input logic [3:0] a);
        if (a < 4'(ND)) return {21'd0, m_digit[a]};
        else if (a == 4'd8) return {30'd0, phase_now(), m_enable};
        else if (a == 4'd9) return {31'd0, m_btn};
        else if (a == 4'd10) return {31'd0, m_edge};
        else if (a == 4'd11) return {31'd0, m_mask};
        else return 32'd0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_digit[i] = 11'h200;
        m_enable = 1'b1;
        m_mask   = 1'b0;
        m_edge   = 1'b0;
        m_btn    = 1'b1;
        m_b1     = 1'b1;
        m_b2     = 1'b1;
        m_run    = 0;
        m_n      = 0;
        m_rdata  = 32'd0;
    endtask

    // One clock: predict outputs from the pre-edge state, advance the model, compare.
    task automatic tick();
        logic [8*ND-1:0] e_hex;
        logic            e_irq;
        logic            press;
        e_hex = exp_hex();
        e_irq = m_edge & m_mask;
        if (bus.read) m_rdata = model_read(bus.address);
        if (bus.write) begin
            if (bus.address < 4'(ND)) m_digit[bus.address] = bus.writedata[10:0];
            else if (bus.address == 4'd8) m_enable = bus.writedata[0];
            else if (bus.address == 4'd11) m_mask = bus.writedata[0];
        end
        press = 1'b0;
        if (m_b2 != m_btn) begin
            m_run++;
            if (m_run == DC) begin
                press = (m_b2 == 1'b0);
                m_btn = m_b2;
                m_run = 0;
            end
        end else begin
            m_run = 0;
        end
        m_b2 = m_b1;
        m_b1 = button_n;
        if (press) m_edge = 1'b1;
        else if (bus.write && bus.address == 4'd10 && bus.writedata[0]) m_edge = 1'b0;
        m_n++;
        @(posedge clk);
        #1;
        chk("readdata", bus.readdata, m_rdata);
        chk("hex_n", hex_n, e_hex);
        chk("irq", irq, e_irq);
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        bus.address   = a;
        bus.writedata = d;
        bus.write     = 1'b1;
        tick();
        bus.write     = 1'b0;
    endtask

    task automatic rd(input logic [3:0] a);
        bus.address = a;
        bus.read    = 1'b1;
        tick();
        bus.read    = 1'b0;
    endtask

    logic [7:0]  blink_b [16];
    logic [31:0] r1, r2;
    logic [1:0]  op;

    initial begin
        seg_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        bus.address   = 4'd0;
        bus.read      = 1'b0;
        bus.write     = 1'b0;
        bus.writedata = 32'd0;
        button_n      = 1'b1;
        reset         = 1'b0;
        #1 reset = 1'b1;
        #1;
        chk("rst_readdata", bus.readdata, 32'd0);
        chk("rst_hex", hex_n, {(8*ND){1'b1}});
        chk("rst_irq", irq, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b0;
        model_reset();

        // Decode, dp, raw and blank on digit 0
        wr(4'd0, 32'h003); idle(1); chk("dec_3", hex_n[7:0], 8'hB0);
        wr(4'd0, 32'h013); idle(1); chk("dec_3_dp", hex_n[7:0], 8'h30);
        wr(4'd0, 32'h1FF); idle(1); chk("raw_ff", hex_n[7:0], 8'h00);
        wr(4'd0, 32'h200); idle(1); chk("blank", hex_n[7:0], 8'hFF);

        // Unmapped digit index and address
        wr(4'd0, 32'h00A); idle(1);
        wr(4'd7, 32'h005); idle(2);
        chk("dig7_no_hex", hex_n, 48'hFFFF_FFFF_FF88);
        rd(4'd0); chk("rd_dig0", bus.readdata, 32'h00A);
        rd(4'd7); chk("rd_dig7", bus.readdata, 32'd0);
        rd(4'd0);
        rd(4'd12); chk("rd_addr12", bus.readdata, 32'd0);

        // Blinking digit alternates with a 4-cycle half period
        wr(4'd1, 32'h408); idle(2);
        for (int k = 0; k < 16; k++) begin
            tick();
            blink_b[k] = hex_n[15:8];
        end
        for (int k = 0; k < 12; k++) begin
            chk("blink_alt", ((blink_b[k + 4] != blink_b[k]) &&
                              (blink_b[k] == 8'h80 || blink_b[k] == 8'hFF)), 1'b1);
        end
        wr(4'd8, 32'h0); idle(1);
        chk("disabled_all_ff", hex_n, {(8*ND){1'b1}});
        rd(4'd8); r1 = bus.readdata;
        idle(3);
        rd(4'd8); r2 = bus.readdata;
        chk("ctrl_en0", r1[0], 1'b0);
        chk("ctrl_phase_toggles", r1[1] ^ r2[1], 1'b1);
        wr(4'd8, 32'h1); idle(1);

        // Short glitch ignored, long press captured, irq mask and clear, release ignored
        button_n = 1'b0; idle(5); button_n = 1'b1; idle(15);
        rd(4'd9);  chk("glitch_btn", bus.readdata, 32'd1);
        rd(4'd10); chk("glitch_edge", bus.readdata, 32'd0);
        button_n = 1'b0; idle(20);
        rd(4'd9);  chk("press_btn", bus.readdata, 32'd0);
        rd(4'd10); chk("press_edge", bus.readdata, 32'd1);
        wr(4'd11, 32'h1); idle(1); chk("irq_set", irq, 1'b1);
        wr(4'd10, 32'h1); idle(1); chk("irq_clr", irq, 1'b0);
        button_n = 1'b1; idle(20);
        rd(4'd10); chk("release_edge", bus.readdata, 32'd0);

        // Press completing on the same edge as an EDGE clear
        button_n = 1'b0; idle(20);
        rd(4'd10); chk("press2_edge", bus.readdata, 32'd1);
        button_n = 1'b1; idle(20);
        rd(4'd10); chk("release2_edge", bus.readdata, 32'd1);
        button_n = 1'b0; idle(9);
        wr(4'd10, 32'h1); chk("race_irq0", irq, 1'b1);
        idle(1); chk("race_irq1", irq, 1'b1);
        rd(4'd10); chk("race_edge", bus.readdata, 32'd1);

        // Reset mid-blink and mid-debounce
        button_n = 1'b1; idle(3);
        rd(4'd1);
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_readdata", bus.readdata, 32'd0);
        chk("mid_rst_hex", hex_n, {(8*ND){1'b1}});
        chk("mid_rst_irq", irq, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b0;
        model_reset();
        idle(12);
        chk("post_rst_irq", irq, 1'b0);
        rd(4'd10); chk("post_rst_edge", bus.readdata, 32'd0);
        rd(4'd9);  chk("post_rst_btn", bus.readdata, 32'd1);
        rd(4'd0);  chk("post_rst_dig0", bus.readdata, 32'h200);

        // Random bus and button traffic against the model
        for (int it = 0; it < 500; it++) begin
            if ($urandom_range(0, 7) == 0) button_n = ~button_n;
            op            = 2'($urandom_range(0, 3));
            bus.read      = op[0];
            bus.write     = op[1];
            bus.address   = 4'($urandom_range(0, 15));
            bus.writedata = $urandom();
            tick();
        end
        bus.read  = 1'b0;
        bus.write = 1'b0;
        idle(2);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
